// File: rtl/canny_pass_sequencer.sv
// Sequences the median/gaussian/sobel/non-max/hysteresis passes over the image register file.
// Optional SEQ_STALL_EN adds a stall input that pauses column issue and border padding.
module canny_pass_sequencer #(
  parameter int unsigned IMG_DIM   = 20,
  parameter int unsigned AW        = 9,
  parameter int unsigned DRAIN_MAX = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_end,
  input  logic          mod_readable,
`ifdef SEQ_STALL_EN
  input  logic          stall,
`endif
  output logic [2:0]    op_out,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic          col_first,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          pad_en,
  output logic [AW-1:0] pad_src,
  output logic [AW-1:0] pad_dst,
  output logic          wb_en,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned IW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_OP, S_SCAN, S_DRAIN, S_PAD, S_WRITE_BACK, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0, OP_MED = 3'd1, OP_GAU = 3'd2, OP_SOB = 3'd3, OP_NMS = 3'd4, OP_HYS = 3'd5
  } op_t;

  state_t        state;
  op_t           op;
  logic [AW-1:0] row, col;
  logic [AW-1:0] rd_ptr, wr_ptr, wr_cnt, wr_col;
  logic [IW-1:0] idle_cnt;
  logic [AW-1:0] m, hi, last_row, span, n_writes;
  logic          hold;

`ifdef SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  function automatic op_t next_op(input op_t o);
    case (o)
      OP_IDLE: return OP_MED;
      OP_MED:  return OP_GAU;
      OP_GAU:  return OP_SOB;
      OP_SOB:  return OP_NMS;
      default: return OP_HYS;
    endcase
  endfunction

  function automatic logic [AW-1:0] margin(input op_t o);
    return (o == OP_GAU) ? AW'(2) : AW'(1);
  endfunction

  function automatic logic [AW-1:0] clamp(input logic [AW-1:0] v, input logic [AW-1:0] lo,
                                          input logic [AW-1:0] hi_lim);
    if (v < lo) return lo;
    if (v > hi_lim) return hi_lim;
    return v;
  endfunction

  assign m        = margin(op);
  assign hi       = AW'(IMG_DIM - 1) - m;
  assign last_row = hi - m;
  assign span     = AW'(IMG_DIM) - (m << 1);
  assign n_writes = span * span;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= OP_IDLE;
      row      <= '0;
      col      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      wr_cnt   <= '0;
      wr_col   <= '0;
      idle_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_col == span - 1'b1) begin
          wr_col <= '0;
          wr_ptr <= wr_ptr + (m << 1) + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (load_end) begin
          state <= S_SET_OP;
          err   <= 1'b0;
        end
        S_SET_OP: begin
          op       <= next_op(op);
          row      <= '0;
          col      <= '0;
          rd_ptr   <= '0;
          wr_cnt   <= '0;
          wr_col   <= '0;
          idle_cnt <= '0;
          wr_ptr   <= margin(next_op(op)) * AW'(IMG_DIM + 1);
          state    <= S_SCAN;
        end
        // Rows are contiguous in memory, so the read pointer simply counts up across rows.
        S_SCAN: if (!hold) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (col == AW'(IMG_DIM - 1)) begin
            col <= '0;
            if (row == last_row) begin
              row   <= '0;
              state <= S_DRAIN;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DRAIN: begin
          if (wr_cnt == n_writes) begin
            idle_cnt <= '0;
            state    <= (op == OP_HYS) ? S_DONE : S_PAD;
          end else if (wr_en) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IW'(DRAIN_MAX - 1)) begin
            idle_cnt <= '0;
            err      <= 1'b1;
            state    <= (op == OP_HYS) ? S_DONE : S_PAD;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        // Raster walk over the border ring; interior rows jump straight to the right margin.
        S_PAD: if (!hold) begin
          if (col == AW'(IMG_DIM - 1)) begin
            col <= '0;
            if (row == AW'(IMG_DIM - 1)) begin
              row   <= '0;
              state <= S_WRITE_BACK;
            end else begin
              row <= row + 1'b1;
            end
          end else if (row >= m && row <= hi && col == m - 1'b1) begin
            col <= hi + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_WRITE_BACK: state <= S_SET_OP;
        S_DONE: begin
          op    <= OP_IDLE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign op_out    = op;
  assign rd_valid  = (state == S_SCAN) && !hold;
  assign rd_addr   = (state == S_SCAN) ? rd_ptr : '0;
  assign col_first = rd_valid && (col == '0);
  assign wr_en     = mod_readable && (state == S_SCAN || state == S_DRAIN) && (wr_cnt < n_writes);
  assign wr_addr   = wr_en ? wr_ptr : '0;
  assign pad_en    = (state == S_PAD) && !hold;
  assign pad_dst   = (state == S_PAD) ? row * AW'(IMG_DIM) + col : '0;
  assign pad_src   = (state == S_PAD) ? clamp(row, m, hi) * AW'(IMG_DIM) + clamp(col, m, hi) : '0;
  assign wb_en     = (state == S_WRITE_BACK);
  assign done      = (state == S_DONE);
  assign busy      = (state == S_SET_OP) || (state == S_SCAN) || (state == S_DRAIN) ||
                     (state == S_PAD) || (state == S_WRITE_BACK);

endmodule
